sseg_scan_monitor: RTL and testbench
====================================

Name: sseg_scan_monitor

Overview:
- Observer at the far end of the multiplexed 7-segment bus (active-low an[7:0], sseg[7:0]) driven by the square-rotator display logic.
- Synchronizes and debounces the bus, then decodes the lit digit and glyph back into the rotator's 3-bit position code.
- Tracks step direction and a signed step count, and flags illegal bus states.
- Used for on-board self-check and as a reusable bench monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a bus state is accepted (range 1..255).
- STEP_W, 16, width of step counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- an  in  8  digit enables, active-low, asynchronous to clk
- sseg  in  8  segment pattern, active-low, {dp,g,f,e,d,c,b,a}
- pos  out  3  last accepted position code
- pos_known  out  1  at least one legal position accepted since reset
- pos_stb  out  1  one-cycle pulse: pos updated to a new value
- dir_cw  out  1  direction of last legal step (1 = increment)
- step_cnt  out  STEP_W  +1 per cw step, -1 per ccw step, modulo 2^STEP_W
- err_pattern  out  1  one-cycle pulse: accepted state has a single digit but an illegal glyph/digit
- err_multi  out  1  one-cycle pulse: accepted state has more than one digit low
- err_skip  out  1  one-cycle pulse: position jumped by more than ±1 (mod 8)

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. All flops use rst.
- Reset values:
  - pos=0, pos_known=0, pos_stb=0, dir_cw=1, step_cnt=0, all err_*=0.
  - Sync stages and previous-sample register = 16'hFFFF.
  - Stability counter = STABLE_CYCLES (saturated, so nothing is accepted at start-up).
- Synchronizer: two flops on the 16-bit {an,sseg} word (s1→s2). prev <= s2 each cycle.
- Stability counter:
  - s2≠prev: cnt<=0.
  - Otherwise, if cnt<STABLE_CYCLES: cnt<=cnt+1. It saturates at STABLE_CYCLES.
  - accept = (s2==prev) && (cnt==STABLE_CYCLES-1). This fires exactly once per stable run.
- Latency: inputs changed before edge 1 and held constant → outputs/pulses update at edge 3+STABLE_CYCLES (edge 7 at default).
- Classification at accept:
  - an==8'hFF: blank. No action, no error.
  - More than one an bit low: err_multi.
  - Exactly one bit low, at index d:
    - sseg==8'b10011100 (upper square) and d∈{3,2,1,0} → position p = 3-d (d=3→0 … d=0→3).
    - sseg==8'b10100011 (lower square) and d∈{0,1,2,3} → p = 4+d (d=0→4 … d=3→7).
    - Any other glyph, or d≥4 → err_pattern. Position state is unchanged.
- Position update for a legal p:
  - pos_known=0: pos<=p, pos_known<=1, pos_stb=1. No step, dir_cw and step_cnt unchanged.
  - p==pos: no action, no pulse.
  - p==pos+1 mod 8: pos<=p, pos_stb, dir_cw<=1, step_cnt+1.
  - p==pos-1 mod 8: pos<=p, pos_stb, dir_cw<=0, step_cnt-1.
  - Otherwise: pos<=p, pos_stb, err_skip. dir_cw and step_cnt unchanged.
- Wrap-around: 7→0 is a cw step and 0→7 is a ccw step. step_cnt wraps 2^STEP_W-1↔0 silently.
- Unstable bus: a bus that toggles faster than STABLE_CYCLES+1 cycles is never accepted and never produces errors.
- Pulses: all pulses are registered, exactly one cycle wide. At most one of pos_stb and err_pattern/err_multi is asserted per accept. err_skip is always accompanied by pos_stb.
- rst mid-operation: all state returns to reset values immediately. The first legal state after release is treated as the first-ever position, with no step counted.

Test Plan:
- Reset, then an=8'hF7, sseg=8'h9C held 20 cycles → pos_stb pulse at edge 7 after change, pos=0, pos_known=1, step_cnt=0, dir_cw=1.
- Continue an=8'hFB→FD→FE (sseg 8'h9C), then an=8'hFE with sseg=8'hA3, each held 20 cycles → pos 1,2,3,4, four pos_stb, step_cnt=4, dir_cw=1.
- From pos=0, apply an=8'hF7, sseg=8'hA3 (p=7) → ccw step, dir_cw=0, step_cnt=0xFFFF. Then return to p=0 → cw step, step_cnt=0.
- From pos=1, apply an=8'hFE with sseg=8'hA3 (p=4) → pos=4, pos_stb+err_skip, step_cnt unchanged.
- Illegal states, each held 20 cycles, expecting exactly one pulse each with pos unchanged:
  - an=8'hF3 → err_multi.
  - an=8'hEF, sseg=8'h9C → err_pattern.
  - an=8'hFE, sseg=8'hC0 → err_pattern.
  - an=8'hFF → no pulse.
- Glitch/reset:
  - Toggle an between 8'hF7 and 8'hFB every 3 cycles for 50 cycles → no pulses.
  - Assert rst mid-run with pos=5, step_cnt=5 → all outputs 0 (dir_cw=1) immediately. The next legal state yields pos_stb with step_cnt still 0.

Source files
------------

// File: rtl/sseg_scan_monitor.sv
// sseg_scan_monitor
//
// Purpose:
//   Watches the far end of a multiplexed 7-segment bus driven by the
//   square-rotator display. It synchronizes and debounces the bus, decodes
//   the lit digit and glyph back into the rotator's 3-bit position code,
//   tracks step direction and a signed step count, and flags illegal bus
//   states. It is used for on-board self-check and as a reusable monitor.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical synchronized samples required
//                  before a bus state is accepted (1..255)
//   STEP_W         width of the step counter
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   an[7:0]      digit enables, active-low, asynchronous to clk
//   sseg[7:0]    segment pattern, active-low, {dp,g,f,e,d,c,b,a}
//   pos          last accepted position code
//   pos_known    at least one legal position accepted since reset
//   pos_stb      one-cycle pulse: pos updated to a new value
//   dir_cw       direction of the last legal step (1 = increment)
//   step_cnt     +1 per cw step, -1 per ccw step, modulo 2^STEP_W
//   err_pattern  one-cycle pulse: single digit lit, but illegal glyph/digit
//   err_multi    one-cycle pulse: more than one digit lit
//   err_skip     one-cycle pulse: position jumped by more than +/-1 (mod 8)

module sseg_scan_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int STEP_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        an,
  input  logic [7:0]        sseg,
  output logic [2:0]        pos,
  output logic              pos_known,
  output logic              pos_stb,
  output logic              dir_cw,
  output logic [STEP_W-1:0] step_cnt,
  output logic              err_pattern,
  output logic              err_multi,
  output logic              err_skip
);

  // Glyphs the rotator draws: a small square in the upper or lower half.
  localparam logic [7:0] GLYPH_UPPER = 8'b1001_1100;
  localparam logic [7:0] GLYPH_LOWER = 8'b1010_0011;

  localparam logic [7:0]        STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BUS_BLANK,
    BUS_MULTI,
    BUS_BAD,
    BUS_POS
  } bus_class_t;

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] prev;
  logic [7:0]  stable_cnt;
  logic        accept;

  logic [7:0]  an_s;
  logic [7:0]  seg_s;
  logic [7:0]  lit;
  logic        lit_multi;
  logic [2:0]  digit;
  logic [2:0]  new_pos;
  logic [2:0]  delta;
  bus_class_t  bus_class;

  // Two-flop synchronizer on the whole {an,sseg} word plus a one-sample
  // history. Everything resets to the all-off bus so start-up looks blank.
  // The stability counter starts saturated so nothing is accepted until the
  // bus actually changes and then settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 16'hFFFF;
      sync2      <= 16'hFFFF;
      prev       <= 16'hFFFF;
      stable_cnt <= STABLE_MAX;
    end else begin
      sync1 <= {an, sseg};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt < STABLE_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  // The counter passes through STABLE_CYCLES-1 exactly once per stable run
  // before saturating, so accept is a single-cycle event per bus state.
  assign accept = (sync2 == prev) && (stable_cnt == STABLE_MAX - 8'd1);

  assign an_s      = sync2[15:8];
  assign seg_s     = sync2[7:0];
  assign lit       = ~an_s;
  assign lit_multi = (lit & (lit - 8'd1)) != 8'd0;

  // Index of the lit digit; only meaningful when exactly one bit is set.
  always_comb begin
    digit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (lit[i]) begin
        digit = 3'(i);
      end
    end
  end

  // Map the accepted bus state onto a class and, for legal states, the
  // rotator position. Upper squares walk digits 3..0 as positions 0..3,
  // lower squares walk digits 0..3 as positions 4..7.
  always_comb begin
    bus_class = BUS_BLANK;
    new_pos   = 3'd0;
    if (lit == 8'd0) begin
      bus_class = BUS_BLANK;
    end else if (lit_multi) begin
      bus_class = BUS_MULTI;
    end else if (seg_s == GLYPH_UPPER && !digit[2]) begin
      bus_class = BUS_POS;
      new_pos   = 3'd3 - digit;
    end else if (seg_s == GLYPH_LOWER && !digit[2]) begin
      bus_class = BUS_POS;
      new_pos   = 3'd4 + digit;
    end else begin
      bus_class = BUS_BAD;
    end
  end

  // Modulo-8 distance from the current position: 1 is a cw step,
  // 7 a ccw step, 0 no movement, anything else a skip.
  assign delta = new_pos - pos;

  // Position tracking and pulse generation. Pulses default low every cycle
  // so each one is exactly one clock wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos         <= 3'd0;
      pos_known   <= 1'b0;
      pos_stb     <= 1'b0;
      dir_cw      <= 1'b1;
      step_cnt    <= '0;
      err_pattern <= 1'b0;
      err_multi   <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      pos_stb     <= 1'b0;
      err_pattern <= 1'b0;
      err_multi   <= 1'b0;
      err_skip    <= 1'b0;
      if (accept) begin
        case (bus_class)
          BUS_MULTI: err_multi   <= 1'b1;
          BUS_BAD:   err_pattern <= 1'b1;
          BUS_POS: begin
            if (!pos_known) begin
              pos       <= new_pos;
              pos_known <= 1'b1;
              pos_stb   <= 1'b1;
            end else if (delta == 3'd1) begin
              pos      <= new_pos;
              pos_stb  <= 1'b1;
              dir_cw   <= 1'b1;
              step_cnt <= step_cnt + STEP_ONE;
            end else if (delta == 3'd7) begin
              pos      <= new_pos;
              pos_stb  <= 1'b1;
              dir_cw   <= 1'b0;
              step_cnt <= step_cnt - STEP_ONE;
            end else if (delta != 3'd0) begin
              pos      <= new_pos;
              pos_stb  <= 1'b1;
              err_skip <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_monitor.sv
// tb_sseg_scan_monitor
//
// Purpose:
//   Directed self-checking bench for sseg_scan_monitor. Each bus state is
//   held for a number of cycles while pulses are counted, then the counts
//   and the tracked position state are compared against hand-computed
//   values.

module tb_sseg_scan_monitor;

  localparam int STABLE_CYCLES = 4;
  localparam int STEP_W        = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        an;
  logic [7:0]        sseg;
  logic [2:0]        pos;
  logic              pos_known;
  logic              pos_stb;
  logic              dir_cw;
  logic [STEP_W-1:0] step_cnt;
  logic              err_pattern;
  logic              err_multi;
  logic              err_skip;

  int vectors_applied = 0;
  int miscompares     = 0;

  int n_stb;
  int n_pat;
  int n_multi;
  int n_skip;
  int first_stb_edge;

  sseg_scan_monitor #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .STEP_W       (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .an         (an),
    .sseg       (sseg),
    .pos        (pos),
    .pos_known  (pos_known),
    .pos_stb    (pos_stb),
    .dir_cw     (dir_cw),
    .step_cnt   (step_cnt),
    .err_pattern(err_pattern),
    .err_multi  (err_multi),
    .err_skip   (err_skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounts();
    n_stb          = 0;
    n_pat          = 0;
    n_multi        = 0;
    n_skip         = 0;
    first_stb_edge = 0;
  endtask

  // Drive a bus state on the falling edge, then sample every rising edge
  // (1 time unit after it) for the given number of cycles, counting pulses.
  task automatic applyStimulus(input logic [7:0] an_v, input logic [7:0] seg_v,
                               input int cycles);
    clearCounts();
    @(negedge clk);
    an   = an_v;
    sseg = seg_v;
    for (int e = 1; e <= cycles; e++) begin
      @(posedge clk);
      #1;
      if (pos_stb) begin
        n_stb++;
        if (first_stb_edge == 0) first_stb_edge = e;
      end
      if (err_pattern) n_pat++;
      if (err_multi)   n_multi++;
      if (err_skip)    n_skip++;
    end
  endtask

  task automatic expectHold(input string tag, input logic [7:0] an_v,
                            input logic [7:0] seg_v, input int exp_pos,
                            input int exp_stb, input int exp_pat,
                            input int exp_multi, input int exp_skip,
                            input int exp_cnt, input int exp_dir);
    applyStimulus(an_v, seg_v, 20);
    checkOutput($sformatf("%s pos", tag), 32'(pos), 32'(exp_pos));
    checkOutput($sformatf("%s pos_known", tag), 32'(pos_known), 32'd1);
    checkOutput($sformatf("%s stb", tag), 32'(n_stb), 32'(exp_stb));
    checkOutput($sformatf("%s err_pattern", tag), 32'(n_pat), 32'(exp_pat));
    checkOutput($sformatf("%s err_multi", tag), 32'(n_multi), 32'(exp_multi));
    checkOutput($sformatf("%s err_skip", tag), 32'(n_skip), 32'(exp_skip));
    checkOutput($sformatf("%s step_cnt", tag), 32'(step_cnt), 32'(exp_cnt));
    checkOutput($sformatf("%s dir_cw", tag), 32'(dir_cw), 32'(exp_dir));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst  = 1'b1;
    an   = 8'hFF;
    sseg = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput($sformatf("%s pos", tag), 32'(pos), 32'd0);
    checkOutput($sformatf("%s pos_known", tag), 32'(pos_known), 32'd0);
    checkOutput($sformatf("%s pos_stb", tag), 32'(pos_stb), 32'd0);
    checkOutput($sformatf("%s dir_cw", tag), 32'(dir_cw), 32'd1);
    checkOutput($sformatf("%s step_cnt", tag), 32'(step_cnt), 32'd0);
    checkOutput($sformatf("%s errs", tag),
                32'({err_pattern, err_multi, err_skip}), 32'd0);
  endtask

  initial begin
    int glitch_pulses;

    rst  = 1'b1;
    an   = 8'hFF;
    sseg = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] first position and latency");
    expectHold("p0 first", 8'hF7, 8'h9C, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("p0 latency", 32'(first_stb_edge), 32'(3 + STABLE_CYCLES));

    $display("[TB] wrap-around steps");
    expectHold("p0->p7", 8'hF7, 8'hA3, 7, 1, 0, 0, 0, 16'hFFFF, 0);
    expectHold("p7->p0", 8'hF7, 8'h9C, 0, 1, 0, 0, 0, 0, 1);

    $display("[TB] clockwise walk");
    expectHold("p1", 8'hFB, 8'h9C, 1, 1, 0, 0, 0, 1, 1);
    expectHold("p2", 8'hFD, 8'h9C, 2, 1, 0, 0, 0, 2, 1);
    expectHold("p3", 8'hFE, 8'h9C, 3, 1, 0, 0, 0, 3, 1);
    expectHold("p4", 8'hFE, 8'hA3, 4, 1, 0, 0, 0, 4, 1);
    expectHold("p4 same", 8'hFE, 8'hA3, 4, 0, 0, 0, 0, 4, 1);

    $display("[TB] ccw walk and skip");
    expectHold("ccw p3", 8'hFE, 8'h9C, 3, 1, 0, 0, 0, 3, 0);
    expectHold("ccw p2", 8'hFD, 8'h9C, 2, 1, 0, 0, 0, 2, 0);
    expectHold("ccw p1", 8'hFB, 8'h9C, 1, 1, 0, 0, 0, 1, 0);
    expectHold("skip p4", 8'hFE, 8'hA3, 4, 1, 0, 0, 1, 1, 0);

    $display("[TB] illegal bus states");
    expectHold("multi", 8'hF3, 8'h9C, 4, 0, 0, 1, 0, 1, 0);
    expectHold("digit4", 8'hEF, 8'h9C, 4, 0, 1, 0, 0, 1, 0);
    expectHold("glyph", 8'hFE, 8'hC0, 4, 0, 1, 0, 0, 1, 0);
    expectHold("blank", 8'hFF, 8'hC0, 4, 0, 0, 0, 0, 1, 0);

    $display("[TB] glitching bus");
    glitch_pulses = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      an   = (i % 2 == 0) ? 8'hF7 : 8'hFB;
      sseg = 8'h9C;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        if (pos_stb || err_pattern || err_multi || err_skip) glitch_pulses++;
      end
    end
    checkOutput("glitch pulses", 32'(glitch_pulses), 32'd0);
    expectHold("glitch settle", 8'hF7, 8'h9C, 0, 1, 0, 0, 1, 1, 0);

    $display("[TB] reset mid-run");
    pulseReset();
    expectHold("rr p0", 8'hF7, 8'h9C, 0, 1, 0, 0, 0, 0, 1);
    expectHold("rr p1", 8'hFB, 8'h9C, 1, 1, 0, 0, 0, 1, 1);
    expectHold("rr p2", 8'hFD, 8'h9C, 2, 1, 0, 0, 0, 2, 1);
    expectHold("rr p3", 8'hFE, 8'h9C, 3, 1, 0, 0, 0, 3, 1);
    expectHold("rr p4", 8'hFE, 8'hA3, 4, 1, 0, 0, 0, 4, 1);
    expectHold("rr p5", 8'hFD, 8'hA3, 5, 1, 0, 0, 0, 5, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetState("async rst");
    repeat (2) @(negedge clk);
    an   = 8'hFF;
    sseg = 8'hFF;
    rst  = 1'b0;
    expectHold("post rst p3", 8'hFE, 8'h9C, 3, 1, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors_applied, miscompares);
    $finish;
  end

endmodule
